uart_transmitter: RTL and testbench

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_transmitter_if.sv | 24 ++
 rtl/uart_transmitter.sv | 163 ++++++++++++++++
 tb/tb_uart_transmitter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_transmitter_if.sv
// Transmit-side handshake bundle: byte, request, ready and end-of-frame pulse.
// No latency of its own (wires only); backpressure is carried by tx_ready.
interface uart_transmitter_if #(
    parameter int DBITS = 8
);
    logic [DBITS-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             tx_done;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_done
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_done
    );
endinterface

// File: rtl/uart_transmitter.sv
// Serial UART transmitter: start, DBITS data LSB first, optional parity, STOP_B/16 stop bits.
// txd goes low one sysclk after acceptance; frame is 16*(1+DBITS+parity)+STOP_B baud ticks.
// Holds tx_ready low for the whole frame; requests arriving then are dropped, not queued.
module uart_transmitter #(
    parameter int DBITS  = 8,
    parameter int STOP_B = 16
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic              baudx16_ena,
    input  logic              parity_en,
    input  logic              odd_even,
    output logic              txd,
    uart_transmitter_if.slave bus
);
    localparam int TW = $clog2(STOP_B);
    localparam int BW = (DBITS > 1) ? $clog2(DBITS) : 1;
    localparam logic [TW-1:0] TICK_BIT  = TW'(15);
    localparam logic [TW-1:0] TICK_STOP = TW'(STOP_B - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DBITS - 1);

    typedef enum logic [4:0] {
        sIDLE   = 5'b00001,
        sSTART  = 5'b00010,
        sSHIFT  = 5'b00100,
        sPARITY = 5'b01000,
        sSTOP   = 5'b10000
    } state_t;

    state_t           state_q, state_d;
    logic [DBITS-1:0] shreg_q, shreg_d, shifted;
    logic             par_q, par_d;
    logic             par_en_q, par_en_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             txd_q, txd_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;

    assign shifted      = shreg_q >> 1;
    assign txd          = txd_q;
    assign bus.tx_ready = ready_q;
    assign bus.tx_done  = done_q;

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q  <= sIDLE;
            shreg_q  <= '0;
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
            tick_q   <= '0;
            bit_q    <= '0;
            txd_q    <= 1'b1;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
            par_en_q <= par_en_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            txd_q    <= txd_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    // Outputs are computed one cycle ahead so that every pin comes straight off a flop.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        par_d    = par_q;
        par_en_d = par_en_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        txd_d    = txd_q;
        ready_d  = ready_q;
        done_d   = 1'b0;

        case (state_q)
            sIDLE: begin
                txd_d   = 1'b1;
                ready_d = 1'b1;
                if (bus.tx_valid) begin
                    shreg_d  = bus.tx_data;
                    par_d    = odd_even ^ (^bus.tx_data);
                    par_en_d = parity_en;
                    tick_d   = '0;
                    bit_d    = '0;
                    state_d  = sSTART;
                    txd_d    = 1'b0;
                    ready_d  = 1'b0;
                end
            end
            sSTART: begin
                if (baudx16_ena) begin
                    if (tick_q == TICK_BIT) begin
                        tick_d  = '0;
                        state_d = sSHIFT;
                        txd_d   = shreg_q[0];
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            sSHIFT: begin
                if (baudx16_ena) begin
                    if (tick_q == TICK_BIT) begin
                        tick_d  = '0;
                        shreg_d = shifted;
                        if (bit_q == BIT_LAST) begin
                            bit_d = '0;
                            if (par_en_q) begin
                                state_d = sPARITY;
                                txd_d   = par_q;
                            end else begin
                                state_d = sSTOP;
                                txd_d   = 1'b1;
                            end
                        end else begin
                            bit_d = bit_q + 1'b1;
                            txd_d = shifted[0];
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            sPARITY: begin
                if (baudx16_ena) begin
                    if (tick_q == TICK_BIT) begin
                        tick_d  = '0;
                        state_d = sSTOP;
                        txd_d   = 1'b1;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            sSTOP: begin
                txd_d = 1'b1;
                if (baudx16_ena) begin
                    if (tick_q == TICK_STOP) begin
                        tick_d  = '0;
                        state_d = sIDLE;
                        done_d  = 1'b1;
                        ready_d = 1'b1;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = sIDLE;
                tick_d  = '0;
                bit_d   = '0;
                txd_d   = 1'b1;
                ready_d = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: frame shape, parity, back-to-back, reset abort, 2 stop bits.
module tb_uart_transmitter;
    logic sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    logic rst;
    logic baud;
    logic baud_gate = 1'b1;
    logic parity_en;
    logic odd_even;
    logic txd16, txd32;
    int   ph = 0;
    int   n_vec = 0;
    int   n_miss = 0;

    uart_transmitter_if #(.DBITS(8)) if16();
    uart_transmitter_if #(.DBITS(8)) if32();

    uart_transmitter #(.DBITS(8), .STOP_B(16)) dut16 (
        .sysclk      (sysclk),
        .rst         (rst),
        .baudx16_ena (baud),
        .parity_en   (parity_en),
        .odd_even    (odd_even),
        .txd         (txd16),
        .bus         (if16)
    );

    uart_transmitter #(.DBITS(8), .STOP_B(32)) dut32 (
        .sysclk      (sysclk),
        .rst         (rst),
        .baudx16_ena (baud),
        .parity_en   (parity_en),
        .odd_even    (odd_even),
        .txd         (txd32),
        .bus         (if32)
    );

    // Baud tick on every 4th sysclk, changed just after the rising edge.
    initial begin
        baud = 1'b0;
        forever begin
            @(posedge sysclk);
            #1;
            ph   = (ph + 1) % 4;
            baud = baud_gate && (ph == 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input bit big, input logic [7:0] d, input logic v);
        if (big) begin
            if32.tx_data  = d;
            if32.tx_valid = v;
        end else begin
            if16.tx_data  = d;
            if16.tx_valid = v;
        end
    endtask

    // Called on a falling edge; returns on the falling edge where tx_done is seen (or after abort).
    task automatic frame(input bit big, input logic [7:0] data, input logic pe, input logic oe,
                         input bit hold, input bit chg, input logic [7:0] new_data,
                         input bit flip_par, input bit stall, input int abort_at,
                         output int npulse, output logic [15:0] slots, output int glitches,
                         output int rdy_hi, output int waited, output int stall_moves,
                         output bit timed_out);
        int   cyc;
        logic cur_txd, cur_rdy, cur_done, ref_txd;
        npulse = 0; slots = '0; glitches = 0; rdy_hi = 0;
        waited = 0; stall_moves = 0; timed_out = 1'b0;
        parity_en = pe;
        odd_even  = oe;
        set_req(big, data, 1'b1);
        while (!(big ? if32.tx_ready : if16.tx_ready) && waited < 50) begin
            @(negedge sysclk);
            waited++;
        end
        if (waited >= 50) begin
            timed_out = 1'b1;
            set_req(big, data, 1'b0);
            return;
        end
        @(negedge sysclk);
        if (!hold) set_req(big, data, 1'b0);
        cyc = 0;
        while (cyc < 3000) begin
            cur_txd  = big ? txd32 : txd16;
            cur_rdy  = big ? if32.tx_ready : if16.tx_ready;
            cur_done = big ? if32.tx_done : if16.tx_done;
            if (cur_done) break;
            if (npulse == abort_at) begin
                rst = 1'b1;
                @(negedge sysclk);
                rst = 1'b0;
                break;
            end
            if (cur_rdy) rdy_hi++;
            if (chg && npulse == 40) set_req(big, new_data, hold);
            if (flip_par && npulse == 40) begin
                parity_en = ~parity_en;
                odd_even  = ~odd_even;
            end
            if (baud) begin
                if (npulse % 16 == 0) slots[npulse / 16] = cur_txd;
                else if (slots[npulse / 16] !== cur_txd) glitches++;
                npulse++;
                if (stall && npulse == 50) begin
                    baud_gate = 1'b0;
                    @(negedge sysclk);
                    ref_txd = big ? txd32 : txd16;
                    for (int k = 0; k < 100; k++) begin
                        @(negedge sysclk);
                        if ((big ? txd32 : txd16) !== ref_txd) stall_moves++;
                        if (big ? if32.tx_done : if16.tx_done) stall_moves++;
                    end
                    baud_gate = 1'b1;
                end
            end
            cyc++;
            @(negedge sysclk);
        end
        if (cyc >= 3000) timed_out = 1'b1;
    endtask

    int          np, gl, rh, wt, sm, cnt;
    logic [15:0] sl;
    bit          to;

    initial begin
        rst = 1'b1;
        parity_en = 1'b0;
        odd_even  = 1'b0;
        set_req(1'b0, 8'h00, 1'b0);
        set_req(1'b1, 8'h00, 1'b0);
        repeat (3) @(negedge sysclk);
        check("rst_txd16",   32'(txd16), 1);
        check("rst_ready16", 32'(if16.tx_ready), 1);
        check("rst_done16",  32'(if16.tx_done), 0);
        check("rst_txd32",   32'(txd32), 1);
        check("rst_ready32", 32'(if32.tx_ready), 1);
        rst = 1'b0;
        @(negedge sysclk);

        // Plain 0x55, no parity: 0,1,0,1,0,1,0,1,0,1
        frame(0, 8'h55, 0, 0, 0, 0, 8'h00, 0, 0, -1, np, sl, gl, rh, wt, sm, to);
        check("plain_timeout", 32'(to), 0);
        check("plain_len",     32'(np), 160);
        check("plain_bits",    32'(sl[9:0]), 32'h2AA);
        check("plain_hold",    32'(gl), 0);
        check("plain_rdy_low", 32'(rh), 0);
        @(negedge sysclk);
        check("plain_done_1cyc", 32'(if16.tx_done), 0);
        check("plain_idle_txd",  32'(txd16), 1);

        // 0xA5 even parity -> parity bit 0
        frame(0, 8'hA5, 1, 0, 0, 0, 8'h00, 0, 0, -1, np, sl, gl, rh, wt, sm, to);
        check("even_len",  32'(np), 176);
        check("even_bits", 32'(sl[10:0]), 32'h54A);
        check("even_hold", 32'(gl), 0);
        @(negedge sysclk);

        // 0xA5 odd parity, parity_en/odd_even flipped mid-frame -> still parity 1, 176
        frame(0, 8'hA5, 1, 1, 0, 0, 8'h00, 1, 0, -1, np, sl, gl, rh, wt, sm, to);
        check("odd_len",  32'(np), 176);
        check("odd_bits", 32'(sl[10:0]), 32'h74A);
        check("odd_hold", 32'(gl), 0);
        @(negedge sysclk);

        // Back-to-back with tx_valid held: 0x01 then 0x80 (data changed mid-frame 1)
        frame(0, 8'h01, 0, 0, 1, 1, 8'h80, 0, 0, -1, np, sl, gl, rh, wt, sm, to);
        check("b2b1_len",     32'(np), 160);
        check("b2b1_bits",    32'(sl[9:0]), 32'h202);
        check("b2b1_rdy_low", 32'(rh), 0);
        check("b2b_gap_rdy",  32'(if16.tx_ready), 1);
        check("b2b_gap_txd",  32'(txd16), 1);
        frame(0, 8'h80, 0, 0, 0, 0, 8'h00, 0, 0, -1, np, sl, gl, rh, wt, sm, to);
        check("b2b2_wait",    32'(wt), 0);
        check("b2b2_len",     32'(np), 160);
        check("b2b2_bits",    32'(sl[9:0]), 32'h300);
        check("b2b2_hold",    32'(gl), 0);
        check("b2b2_rdy_low", 32'(rh), 0);
        @(negedge sysclk);

        // Reset during data bit 3
        frame(0, 8'h55, 0, 0, 0, 0, 8'h00, 0, 0, 72, np, sl, gl, rh, wt, sm, to);
        check("abort_at",    32'(np), 72);
        check("abort_bits",  32'(sl[3:0]), 32'hA);
        check("abort_txd",   32'(txd16), 1);
        check("abort_ready", 32'(if16.tx_ready), 1);
        check("abort_done",  32'(if16.tx_done), 0);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge sysclk);
            if (if16.tx_done || !txd16) cnt++;
        end
        check("abort_quiet", 32'(cnt), 0);

        // Reset beats tx_valid in the same cycle
        rst = 1'b1;
        set_req(0, 8'h00, 1'b1);
        @(negedge sysclk);
        rst = 1'b0;
        set_req(0, 8'h00, 1'b0);
        check("rstprio_ready", 32'(if16.tx_ready), 1);
        @(negedge sysclk);
        check("rstprio_txd",   32'(txd16), 1);
        check("rstprio_ready2", 32'(if16.tx_ready), 1);

        // Next frame after the abort: 0x3C even parity
        frame(0, 8'h3C, 1, 0, 0, 0, 8'h00, 0, 0, -1, np, sl, gl, rh, wt, sm, to);
        check("recov_timeout", 32'(to), 0);
        check("recov_len",     32'(np), 176);
        check("recov_bits",    32'(sl[10:0]), 32'h478);
        @(negedge sysclk);

        // Two stop bits, 0xFF, with a 100-cycle baud stall mid-frame
        frame(1, 8'hFF, 0, 0, 0, 0, 8'h00, 0, 1, -1, np, sl, gl, rh, wt, sm, to);
        check("stop2_timeout", 32'(to), 0);
        check("stop2_len",     32'(np), 176);
        check("stop2_bits",    32'(sl[10:0]), 32'h7FE);
        check("stop2_hold",    32'(gl), 0);
        check("stop2_stall",   32'(sm), 0);
        check("stop2_rdy_low", 32'(rh), 0);
        @(negedge sysclk);
        check("stop2_done_1cyc", 32'(if32.tx_done), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
